// File: rtl/datamemory_banked.sv
// datamemory_banked: word-addressed synchronous RAM with a valid/ready request
// port, byte-lane write enables, an RD_LAT-stage response pipeline with an
// out-of-range error flag, and a post-reset clear sequencer.
// Optional feature macro: DATAMEMORY_PARITY_EN adds one even-parity bit per
// byte lane, parity checking on read and an inj_par test input.

module datamemory_banked #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DATAMEMORY_PARITY_EN
    input  logic                inj_par,
`endif
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wrt,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int NBE = DATA_W / 8;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     clr_ptr;
    logic              clr_done;
    logic              clr_we;

    logic              acc;
    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     idx;

    logic [DATA_W-1:0] mem [DEPTH];

    // Stage 0: the registered read port plus its control bits
    logic              s0_valid;
    logic              s0_rng_err;
    logic [DATA_W-1:0] s0_data;
    logic              s0_err;
    logic              par_bad;

    logic              out_valid;
    logic              out_err;
    logic [DATA_W-1:0] out_data;

    assign clr_done = (clr_ptr == AW'(DEPTH - 1));
    assign clr_we   = (state == CLEAR);

    // Reset wins over a request presented in the same cycle
    assign acc      = req_valid && req_ready && !rst;
    assign in_range = (req_addr < 32'(DEPTH));
    // The array index is only ever formed from an in-range address
    assign idx      = in_range ? req_addr[AW-1:0] : '0;
    assign wr_en    = acc && req_wrt && in_range;
    assign rd_en    = acc && !req_wrt && in_range;

    // State register and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_ptr <= clr_done ? '0 : clr_ptr + AW'(1);
            end
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Data array: clear writes, byte-lane writes and the synchronous read port
    // NOTE: the array has no reset branch; the clear sequencer zeroes it word by word,
    // which keeps it mappable onto block RAM
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            s0_data <= mem[idx];
        end else if (acc) begin
            s0_data <= '0;
        end
    end

    // Stage-0 valid and range-error bits; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid   <= 1'b0;
            s0_rng_err <= 1'b0;
        end else begin
            s0_valid   <= acc;
            s0_rng_err <= acc && !in_range;
        end
    end

`ifdef DATAMEMORY_PARITY_EN
    logic [NBE-1:0] par_mem [DEPTH];
    logic [NBE-1:0] s0_par;
    logic           s0_rd_ok;

    function automatic logic [NBE-1:0] lane_par(input logic [DATA_W-1:0] d);
        logic [NBE-1:0] p;
        for (int i = 0; i < NBE; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    // Parity array, written alongside the data array; clear stores parity 0
    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (req_be[i]) begin
                    par_mem[idx][i] <= ^req_wdata[8*i +: 8] ^ inj_par;
                end
            end
        end
        if (rd_en) begin
            s0_par <= par_mem[idx];
        end
    end

    // Marks stage-0 entries that carry real array data to be parity checked
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_rd_ok <= 1'b0;
        end else begin
            s0_rd_ok <= rd_en;
        end
    end

    assign par_bad = s0_valid && s0_rd_ok && (lane_par(s0_data) != s0_par);
`else
    assign par_bad = 1'b0;
`endif

    assign s0_err = s0_rng_err || par_bad;

    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign out_valid = s0_valid;
            assign out_err   = s0_err;
            assign out_data  = s0_data;
        end else begin : g_pipe
            logic [RD_LAT-2:0] pv;
            logic [RD_LAT-2:0] pe;
            logic [DATA_W-1:0] pd [RD_LAT-1];

            // Extra response stages: valid and err bits, cleared by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                    pe <= '0;
                end else begin
                    pv[0] <= s0_valid;
                    pe[0] <= s0_err;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                        pe[i] <= pe[i-1];
                    end
                end
            end

            // Extra response stages: data, qualified by the valid bits at the output
            always_ff @(posedge clk) begin
                pd[0] <= s0_data;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            assign out_valid = pv[RD_LAT-2];
            assign out_err   = pe[RD_LAT-2];
            assign out_data  = pd[RD_LAT-2];
        end
    endgenerate

    assign rsp_valid = out_valid;
    assign rsp_err   = out_valid && out_err;
    assign rsp_rdata = out_valid ? out_data : '0;

endmodule

// File: tb/tb_datamemory_banked.sv
// Testbench for datamemory_banked: directed scenarios plus randomized traffic.
// A driver pushes the expected response of every request into a queue; an
// independent monitor pops and compares whenever rsp_valid is seen.
// Define DATAMEMORY_PARITY_EN to also exercise the parity feature.

module tb_datamemory_banked;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wrt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
`ifdef DATAMEMORY_PARITY_EN
    logic        inj_par;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [3:0]  model_bad [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    datamemory_banked #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DATAMEMORY_PARITY_EN
        .inj_par   (inj_par),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wrt   (req_wrt),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            model_bad[i] = '0;
        end
    endtask

    // Drive one request (accepted at the next rising edge) and push its expected response
    task automatic issue(input logic wrt, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic inj);
        exp_t e;
        check("req_ready_at_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wrt   = wrt;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
`ifdef DATAMEMORY_PARITY_EN
        inj_par   = inj;
`endif
        // accepted at edge cyc+1, presented after edge cyc+RD_LAT
        e.due = cyc + RD_LAT;
        e.err = (addr >= DEPTH);
        if (wrt) begin
            e.rdata = '0;
            if (!e.err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        model_mem[addr[3:0]][8*i +: 8] = data[8*i +: 8];
                        model_bad[addr[3:0]][i]        = inj;
                    end
                end
            end
        end else begin
            e.rdata = e.err ? 32'd0 : model_mem[addr[3:0]];
            if (!e.err && model_bad[addr[3:0]] != 4'd0) e.err = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
`ifdef DATAMEMORY_PARITY_EN
        inj_par   = 1'b0;
`endif
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
    endtask

    // One-cycle synchronous reset; responses registered at or after the reset edge are lost
    task automatic do_reset();
        rst = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    // Count the cycles busy stays high after reset; req_ready must be low throughout
    task automatic wait_clear();
        int n;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            check("ready_low_while_busy", 32'(req_ready), 32'd0);
            n++;
        end
        check("clear_cycles", n, DEPTH);
    endtask

    // Monitor: compares every presented response against the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: got no rsp_valid, want one due at cycle %0d (now %0d)", e.due, cyc);
            end
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid with rdata %h err %b, want none (cycle %0d)",
                             rsp_rdata, rsp_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", cyc, e.due);
                end
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                check("rsp_rdata_idle", rsp_rdata, 32'd0);
                check("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wrt   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
`ifdef DATAMEMORY_PARITY_EN
        inj_par   = 1'b0;
`endif
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        wait_clear();

        // Every word reads back as zero after the clear sequence
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i), 32'd0, 4'h0, 1'b0);

        // Byte enables: expected 0xAA22CC44
        issue(1'b1, 32'd5, 32'hAABBCCDD, 4'hF, 1'b0);
        issue(1'b1, 32'd5, 32'h11223344, 4'b0101, 1'b0);
        issue(1'b0, 32'd5, 32'd0, 4'h0, 1'b0);

        // Back-to-back write then read of the same word
        issue(1'b1, 32'd7, 32'h12345678, 4'hF, 1'b0);
        issue(1'b0, 32'd7, 32'd0, 4'h0, 1'b0);

        // be=0 write is a no-op that still responds
        issue(1'b1, 32'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
        issue(1'b0, 32'd7, 32'd0, 4'h0, 1'b0);

        // Out-of-range accesses: dropped write, no aliasing onto word 0
        issue(1'b1, 32'd16, 32'hDEADBEEF, 4'hF, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'd0, 4'h0, 1'b0);
        idle();

`ifdef DATAMEMORY_PARITY_EN
        // Injected parity error, then cleared by a clean rewrite
        issue(1'b1, 32'd2, 32'h000000FF, 4'h1, 1'b1);
        issue(1'b0, 32'd2, 32'd0, 4'h0, 1'b0);
        issue(1'b1, 32'd2, 32'h000000FF, 4'h1, 1'b0);
        issue(1'b0, 32'd2, 32'd0, 4'h0, 1'b0);
        idle();
`endif

        // Reset one cycle after the third of three reads; the clear restarts
        issue(1'b0, 32'd5, 32'd0, 4'h0, 1'b0);
        issue(1'b0, 32'd7, 32'd0, 4'h0, 1'b0);
        issue(1'b0, 32'd0, 32'd0, 4'h0, 1'b0);
        do_reset();
        check("midop_busy", 32'(busy), 32'd1);
        wait_clear();
        issue(1'b0, 32'd5, 32'd0, 4'h0, 1'b0);

        // Randomized traffic with gaps, some out-of-range addresses
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      a = $urandom;
                else if (r == 1) a = 32'(DEPTH) + $urandom_range(0, 3);
                else             a = $urandom_range(0, DEPTH - 1);
                issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            end
        end

        // Drain outstanding responses
        repeat (RD_LAT + 3) idle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
